die_select_latch: RTL and testbench

Parametrised successor to the combinational die-select encoder. Accepts NUM_BUTTONS raw asynchronous push-buttons (D4, D6, D8, D10, D12, D20, test switch by default) and synchronises and debounces each one. Drives a live registered select code plus a latched code committed on a clean single-button press/release, with valid and error strobes. Sits between the board buttons and the roll/RNG and display logic.

---
 rtl/die_select_latch_pkg.sv | 18 +
 rtl/die_select_latch_button_debounce.sv | 39 +++
 rtl/die_select_latch.sv | 128 ++++++++++++
 tb/tb_die_select_latch.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/die_select_latch_pkg.sv
// Shared types and defaults for the die-select button front end.
package die_select_pkg;

  localparam int SEL_W_DEFAULT     = 4;
  localparam int TEST_CODE_DEFAULT = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    MULTI = 2'd2
  } sel_state_t;

  // All-ones code of the given width, reserved for "no valid selection".
  function automatic int unsigned invalid_code(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/die_select_latch_button_debounce.sv
// One push-button: two-flop synchroniser followed by a restart-on-bounce
// stability counter that toggles the debounced level.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      // Any cycle where the synced level agrees restarts the count.
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/die_select_latch.sv
// Debounced die-select encoder with press/release commit FSM.
//   state | meaning
//   IDLE  | no debounced button pressed
//   HELD  | exactly one button pressed, its code held as candidate
//   MULTI | more than one button seen since last all-released; no commit
module die_select_latch
  import die_select_pkg::*;
#(
  parameter int NUM_BUTTONS     = 7,
  parameter int SEL_W           = SEL_W_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TEST_IDX        = 6,
  parameter int TEST_CODE       = TEST_CODE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [SEL_W-1:0]       dieSelect,
  output logic [SEL_W-1:0]       dieLatched,
  output logic                   selValid,
  output logic                   selError
);

  localparam int                INVALID_INT  = int'(invalid_code(SEL_W));
  localparam logic [SEL_W-1:0] INVALID_CODE = SEL_W'(invalid_code(SEL_W));
  localparam bit CFG_OK = (NUM_BUTTONS - 1 < INVALID_INT)
                       && (TEST_CODE != INVALID_INT)
                       && !((TEST_CODE < NUM_BUTTONS) && (TEST_CODE != TEST_IDX));

  generate
    if (!CFG_OK) begin : g_bad_cfg
      $error("die_select_latch: invalid NUM_BUTTONS/SEL_W/TEST_CODE combination");
    end
  endgenerate

  logic [NUM_BUTTONS-1:0] deb;

  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .raw  (buttons[gi]),
      .level(deb[gi])
    );
  end

  int unsigned      n_set;
  logic             one_hot;
  logic             any_set;
  logic [SEL_W-1:0] hit_code;
  logic [SEL_W-1:0] enc_code;

  always_comb begin
    n_set    = 0;
    hit_code = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (deb[i]) begin
        n_set    = n_set + 1;
        hit_code = (i == TEST_IDX) ? SEL_W'(TEST_CODE) : SEL_W'(i);
      end
    end
    one_hot  = (n_set == 1);
    any_set  = (n_set != 0);
    enc_code = one_hot ? hit_code : INVALID_CODE;
  end

  sel_state_t       state_q, state_d;
  logic [SEL_W-1:0] cand_q, cand_d;
  logic [SEL_W-1:0] latched_d;
  logic             valid_d, error_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cand_q     <= INVALID_CODE;
      dieSelect  <= INVALID_CODE;
      dieLatched <= INVALID_CODE;
      selValid   <= 1'b0;
      selError   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      dieSelect  <= enc_code;
      dieLatched <= latched_d;
      selValid   <= valid_d;
      selError   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    latched_d = dieLatched;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (one_hot) begin
          state_d = HELD;
          cand_d  = enc_code;
        end else if (any_set) begin
          state_d = MULTI;
          error_d = 1'b1;
        end
      end
      HELD: begin
        if (!any_set) begin
          state_d   = IDLE;
          latched_d = cand_q;
          valid_d   = 1'b1;
        end else if (!one_hot || (enc_code != cand_q)) begin
          // Added a button or swapped without releasing: never commit.
          state_d = MULTI;
          error_d = 1'b1;
        end
      end
      MULTI: begin
        if (!any_set) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_die_select_latch.sv
// Directed bench for die_select_latch with DEBOUNCE_CYCLES = 4.
module tb_die_select_latch;

  logic       clk;
  logic       rst;
  logic [6:0] buttons;
  logic [3:0] dieSelect;
  logic [3:0] dieLatched;
  logic       selValid;
  logic       selError;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int error_cnt = 0;
  int both_cnt = 0;

  die_select_latch #(
    .NUM_BUTTONS    (7),
    .SEL_W          (4),
    .DEBOUNCE_CYCLES(4),
    .TEST_IDX       (6),
    .TEST_CODE      (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .buttons   (buttons),
    .dieSelect (dieSelect),
    .dieLatched(dieLatched),
    .selValid  (selValid),
    .selError  (selError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (selValid === 1'b1) valid_cnt++;
    if (selError === 1'b1) error_cnt++;
    if (selValid === 1'b1 && selError === 1'b1) both_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b0;
    buttons = '0;
    #1;
    buttons = 7'($urandom);
    rst     = 1'b1;
    #1;
    check("rst_select",  {28'd0, dieSelect},  32'hF);
    check("rst_latched", {28'd0, dieLatched}, 32'hF);
    check("rst_valid",   {31'd0, selValid},   32'h0);
    check("rst_error",   {31'd0, selError},   32'h0);
    step(2);
    buttons = '0;
    step(3);
    rst = 1'b0;
    step(2);
    valid_cnt = 0; error_cnt = 0; both_cnt = 0;

    // Clean press of button 1, held 20 cycles, then released.
    buttons = 7'b0000010;
    step(6);
    check("d6_press_early", {28'd0, dieSelect}, 32'hF);
    step(1);
    check("d6_press_edge7", {28'd0, dieSelect}, 32'h1);
    step(13);
    check("d6_held_latched", {28'd0, dieLatched}, 32'hF);
    buttons = 7'b0000000;
    step(6);
    check("d6_rel_early", {28'd0, dieSelect}, 32'h1);
    check("d6_rel_nocommit", {28'd0, dieLatched}, 32'hF);
    step(1);
    check("d6_rel_edge7", {28'd0, dieSelect}, 32'hF);
    check("d6_commit", {28'd0, dieLatched}, 32'h1);
    check("d6_valid_hi", {31'd0, selValid}, 32'h1);
    step(1);
    check("d6_valid_lo", {31'd0, selValid}, 32'h0);
    step(3);
    check("d6_valid_cnt", valid_cnt, 1);
    check("d6_error_cnt", error_cnt, 0);

    // Bouncing button 2: 2-cycle highs and lows never reach 4 stable cycles.
    valid_cnt = 0; error_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      buttons = 7'b0000100;
      step(2);
      buttons = 7'b0000000;
      step(2);
      check("bounce_select", {28'd0, dieSelect}, 32'hF);
    end
    check("bounce_strobes", valid_cnt + error_cnt, 0);
    buttons = 7'b0000100;
    step(6);
    check("bounce_settle_early", {28'd0, dieSelect}, 32'hF);
    step(1);
    check("bounce_settle_edge7", {28'd0, dieSelect}, 32'h2);
    buttons = 7'b0000000;
    step(8);
    check("bounce_commit", {28'd0, dieLatched}, 32'h2);
    check("bounce_valid_cnt", valid_cnt, 1);

    // Test switch encodes to 7.
    valid_cnt = 0; error_cnt = 0;
    buttons = 7'b1000000;
    step(7);
    check("test_select", {28'd0, dieSelect}, 32'h7);
    buttons = 7'b0000000;
    step(7);
    check("test_rel_select", {28'd0, dieSelect}, 32'hF);
    check("test_commit", {28'd0, dieLatched}, 32'h7);
    step(2);
    check("test_valid_cnt", valid_cnt, 1);

    // Multiple buttons: press 1, then add 3 and 5.
    valid_cnt = 0; error_cnt = 0;
    buttons = 7'b0000010;
    step(7);
    check("multi_first", {28'd0, dieSelect}, 32'h1);
    buttons = 7'b0101010;
    step(7);
    check("multi_select", {28'd0, dieSelect}, 32'hF);
    step(3);
    check("multi_error_cnt", error_cnt, 1);
    buttons = 7'b0000000;
    step(10);
    check("multi_no_valid", valid_cnt, 0);
    check("multi_latched_kept", {28'd0, dieLatched}, 32'h7);
    check("multi_error_once", error_cnt, 1);

    // Swap from button 1 to button 2 without release.
    valid_cnt = 0; error_cnt = 0;
    buttons = 7'b0000010;
    step(9);
    buttons = 7'b0000100;
    step(9);
    check("swap_select", {28'd0, dieSelect}, 32'h2);
    check("swap_error_cnt", error_cnt, 1);
    buttons = 7'b0000000;
    step(10);
    check("swap_no_valid", valid_cnt, 0);
    check("swap_latched_kept", {28'd0, dieLatched}, 32'h7);

    // Reset mid-press with button 3 held.
    valid_cnt = 0; error_cnt = 0;
    buttons = 7'b0001000;
    step(7);
    check("rstmid_select", {28'd0, dieSelect}, 32'h3);
    step(2);
    rst = 1'b1;
    #1;
    check("rstmid_select_rst",  {28'd0, dieSelect},  32'hF);
    check("rstmid_latched_rst", {28'd0, dieLatched}, 32'hF);
    check("rstmid_strobes_rst", {30'd0, selValid, selError}, 32'h0);
    step(2);
    rst = 1'b0;
    step(6);
    check("rstmid_repress_early", {28'd0, dieSelect}, 32'hF);
    step(1);
    check("rstmid_repress_edge7", {28'd0, dieSelect}, 32'h3);
    buttons = 7'b0000000;
    step(7);
    check("rstmid_commit", {28'd0, dieLatched}, 32'h3);
    check("rstmid_valid", {31'd0, selValid}, 32'h1);
    step(2);
    check("rstmid_valid_cnt", valid_cnt, 1);
    check("never_both", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
